// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus of the loader
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed big-endian image into instruction memory, holding the CPU in reset
module imem_loader #(parameter int ADDR_W = 8) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  imem_loader_if.slave bus,
  output logic cpu_rst,
  output logic busy,
  output logic done,
  output logic err_ovf,
  output logic [15:0] word_cnt
);
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE} state_t;
  state_t state;
  logic [15:0] len;
  logic [1:0] idx;
  logic [23:0] acc;
  logic xfer;
  assign xfer = bus.in_valid & bus.in_ready;
  // loader FSM; all outputs are registered alongside the state so they change with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cpu_rst <= 1'b1;
      bus.in_ready <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_ovf <= 1'b0;
      word_cnt <= '0;
      len <= '0;
      idx <= '0;
      acc <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state <= LEN_HI;
          bus.in_ready <= 1'b1;
          busy <= 1'b1;
          done <= 1'b0;
          cpu_rst <= 1'b1;
          word_cnt <= '0;
          err_ovf <= 1'b0;
          idx <= '0;
        end
        LEN_HI: if (xfer) begin
          len[15:8] <= bus.in_data;
          state <= LEN_LO;
        end
        LEN_LO: if (xfer) begin
          len[7:0] <= bus.in_data;
          err_ovf <= {1'b0, len[15:8], bus.in_data} > CAP;
          if ({len[15:8], bus.in_data} == 16'd0) begin
            state <= DONE;
            bus.in_ready <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (xfer) begin
          acc <= {acc[15:0], bus.in_data};
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= WRITE;
            bus.in_ready <= 1'b0;
            bus.mem_we <= {1'b0, word_cnt} < CAP;
            bus.mem_addr <= word_cnt[ADDR_W-1:0];
            bus.mem_wdata <= {acc, bus.in_data};
          end
        end
        WRITE: begin
          word_cnt <= word_cnt + 16'd1;
          idx <= '0;
          if (word_cnt + 16'd1 == len) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state <= DATA;
            bus.in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized image loads checked every cycle against a byte-position model
module tb_imem_loader;
  localparam int ADDR_W = 2;
  localparam int CAP = 1 << ADDR_W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cpu_rst, busy, done, err_ovf;
  logic [15:0] word_cnt;
  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .cpu_rst(cpu_rst),
    .busy(busy), .done(done), .err_ovf(err_ovf), .word_cnt(word_cnt)
  );
  always #5 clk = ~clk;
  int total = 0;
  int passed = 0;
  int cyc = 0;
  logic [31:0] img [64];
  logic [63:0] wlog [$];
  logic e_ready = 1'b0, e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_cpu = 1'b1, e_ovf = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [31:0] e_data = '0;
  int e_wc = 0, n = 0, pos = 0;
  bit wpend = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask
  function automatic void finish_load();
    e_done = 1'b1;
    e_cpu = 1'b0;
    e_busy = 1'b0;
    e_ready = 1'b0;
  endfunction
  // reference model: tracks how many bytes of the current image were consumed and what that implies
  always @(posedge clk) begin
    cyc++;
    e_we = 1'b0;
    if (rst) begin
      e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_cpu = 1'b1; e_ovf = 1'b0;
      e_wc = 0; e_addr = '0; e_data = '0; wpend = 1'b0; pos = 0;
    end else if (wpend) begin
      wpend = 1'b0;
      e_wc++;
      if (e_wc == n) finish_load();
      else e_ready = 1'b1;
    end else if (bus.in_valid && e_ready) begin
      pos++;
      if (pos == 1) n = int'(bus.in_data) << 8;
      else if (pos == 2) begin
        n = n | int'(bus.in_data);
        e_ovf = n > CAP;
        if (n == 0) finish_load();
      end else if ((pos - 2) % 4 == 0) begin
        wpend = 1'b1;
        e_ready = 1'b0;
        e_we = e_wc < CAP;
        e_addr = ADDR_W'(e_wc);
        e_data = img[e_wc];
      end
    end else if (start && !e_busy) begin
      pos = 0; e_wc = 0; e_ovf = 0; e_busy = 1'b1; e_ready = 1'b1; e_done = 1'b0; e_cpu = 1'b1;
    end
  end
  // per-cycle comparison against the model, plus a log of every memory write
  always @(negedge clk) begin
    chk("in_ready", 32'(bus.in_ready), 32'(e_ready));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    chk("mem_wdata", bus.mem_wdata, e_data);
    chk("cpu_rst", 32'(cpu_rst), 32'(e_cpu));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("err_ovf", 32'(err_ovf), 32'(e_ovf));
    chk("word_cnt", 32'(word_cnt), 32'(e_wc));
    if (bus.mem_we === 1'b1) wlog.push_back({32'(bus.mem_addr), bus.mem_wdata});
  end
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit v, x;
    for (int g = 0; g < 200; g++) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : ($urandom_range(0, 2) == 0);
      bus.in_valid = v;
      bus.in_data = v ? b : 8'($urandom);
      x = v && bus.in_ready;
      @(negedge clk);
      if (x) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    total++;
    $display("FAIL send_byte: byte %h not accepted within 200 cycles, required acceptance", b);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done();
    for (int g = 0; g < 20 && done !== 1'b1; g++) @(negedge clk);
    chk("done_reached", 32'(done), 32'd1);
  endtask
  task automatic load(input int nw, input int mode);
    logic [15:0] len;
    len = 16'(nw);
    wlog.delete();
    pulse_start();
    send_byte(len[15:8], mode);
    send_byte(len[7:0], mode);
    for (int i = 0; i < nw; i++)
      for (int k = 3; k >= 0; k--) send_byte(img[i][8*k +: 8], mode);
    wait_done();
  endtask
  initial begin
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    start = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    img[0] = 32'h8C010000;
    img[1] = 32'h00221820;
    load(2, 0);
    chk("basic_nwrites", 32'(wlog.size()), 32'd2);
    chk("basic_w0_addr", wlog[0][63:32], 32'd0);
    chk("basic_w0_data", wlog[0][31:0], 32'h8C010000);
    chk("basic_w1_addr", wlog[1][63:32], 32'd1);
    chk("basic_w1_data", wlog[1][31:0], 32'h00221820);
    chk("basic_word_cnt", 32'(word_cnt), 32'd2);
    chk("basic_cpu_rst", 32'(cpu_rst), 32'd0);
    load(2, 1);
    chk("stall_nwrites", 32'(wlog.size()), 32'd2);
    chk("stall_w1_data", wlog[1][31:0], 32'h00221820);
    wlog.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("zero_nwrites", 32'(wlog.size()), 32'd0);
    for (int i = 0; i < 6; i++) img[i] = $urandom;
    load(6, 0);
    chk("ovf_flag", 32'(err_ovf), 32'd1);
    chk("ovf_word_cnt", 32'(word_cnt), 32'd6);
    chk("ovf_nwrites", 32'(wlog.size()), 32'd4);
    chk("ovf_last_addr", wlog[3][63:32], 32'd3);
    chk("ovf_last_data", wlog[3][31:0], img[3]);
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    load(4, 2);
    chk("cap_flag", 32'(err_ovf), 32'd0);
    chk("cap_nwrites", 32'(wlog.size()), 32'd4);
    img[0] = $urandom;
    img[1] = $urandom;
    wlog.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int k = 3; k >= 0; k--) send_byte(img[0][8*k +: 8], 0);
    send_byte(img[1][31:24], 0);
    pulse_start();
    send_byte(img[1][23:16], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_nwrites", 32'(wlog.size()), 32'd1);
    img[0] = $urandom;
    load(1, 0);
    chk("restart_nwrites", 32'(wlog.size()), 32'd1);
    chk("restart_addr", wlog[0][63:32], 32'd0);
    chk("restart_data", wlog[0][31:0], img[0]);
    repeat (8) begin
      int nw;
      nw = $urandom_range(0, 7);
      for (int i = 0; i < nw; i++) img[i] = $urandom;
      if (nw == 0) begin
        wlog.delete();
        pulse_start();
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        wait_done();
      end else begin
        load(nw, 2);
      end
      chk("rand_nwrites", 32'(wlog.size()), 32'(nw < CAP ? nw : CAP));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader and the write side of the pipelined CPU's instruction memory. The CPU core only ever reads that memory.
- Accepts a byte stream over a valid/ready handshake: a 16-bit big-endian word count N, then N big-endian 32-bit instruction words.
- Writes each word to consecutive instruction-memory word addresses starting at 0.
- Holds the CPU in reset until the whole image is written, then releases it.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity CAP = 2^ADDR_W words

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle pulse; begins a load from IDLE or DONE, ignored otherwise
in_valid  input  1  in_data holds a valid byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction-memory write strobe, one cycle per word
mem_addr  output  ADDR_W  word address of the current write
mem_wdata  output  32  instruction word to write
cpu_rst  output  1  reset to the CPU core; high except in DONE
busy  output  1  high in LEN_HI, LEN_LO, DATA, WRITE
done  output  1  high in DONE
err_ovf  output  1  sticky: N > CAP for the current load
word_cnt  output  16  words completed (written or discarded) in the current load

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE, cpu_rst=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err_ovf=0, word_cnt=0, length and byte-index registers=0.
- rst has priority over every other input and aborts a load mid-stream. Partially assembled bytes are dropped; words already written stay in memory.
- Handshake: a byte transfers on a rising edge where in_valid & in_ready. in_ready is a registered state decode: 1 in LEN_HI, LEN_LO, DATA; 0 in IDLE, WRITE, DONE. in_valid with in_ready=0 has no effect.
- States and transitions:
  - IDLE: on start, clear word_cnt, err_ovf and byte index, then go to LEN_HI.
  - LEN_HI: on transfer, N[15:8]=in_data, go to LEN_LO.
  - LEN_LO: on transfer, N[7:0]=in_data. err_ovf = ({N[15:8],in_data} > CAP). Go to DONE if N==0, else DATA.
  - DATA: shift each transferred byte into a 32-bit assembly register, MSB first (first byte lands in [31:24]). On the 4th byte go to WRITE.
  - WRITE: lasts exactly one cycle. mem_wdata = assembled word, mem_addr = word_cnt[ADDR_W-1:0], mem_we = (word_cnt < CAP). word_cnt increments at the end of the cycle. Next state is DONE if word_cnt+1 == N, else DATA with byte index reset.
  - DONE: cpu_rst=0, done=1. On start, go to LEN_HI with cpu_rst back to 1 on the next cycle and word_cnt and err_ovf cleared.
- Latency and throughput:
  - mem_we is asserted the cycle after the 4th byte's transfer edge.
  - Peak throughput is 5 cycles per word (4 byte cycles + 1 write cycle).
  - cpu_rst falls the cycle after the final WRITE cycle, or the cycle after the LEN_LO transfer when N==0.
- Overflow (N > CAP): words with index >= CAP are still consumed and counted but not written (mem_we=0 in their WRITE cycle). Addresses never wrap onto earlier words.
- start is ignored while busy. A start that coincides with rst is ignored.
- mem_addr and mem_wdata hold their last values outside WRITE. mem_we is 0 outside WRITE.
- N==CAP exactly: all CAP words are written, err_ovf stays 0.
- Stalls (in_valid=0) may occur on any byte, with no timeout; the state is held.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 and start=1 -> all outputs at reset values, cpu_rst=1, no transfer occurs.
- Basic load: start, stream 00 02 | 8C 01 00 00 | 00 22 18 20 with in_valid always 1 -> mem_we pulses with (addr 0, 8C010000) then (addr 1, 00221820); each pulse comes one cycle after the 4th byte; done=1 and cpu_rst=0 one cycle after the second pulse; word_cnt=2.
- Backpressure and stalls: same image with in_valid toggling 1,0,0,1… -> identical writes; in_ready=0 during WRITE cycles and no byte is consumed in them.
- Zero length: start, stream 00 00 -> no mem_we, done=1 one cycle after the 2nd byte.
- Overflow (ADDR_W=2, CAP=4): N=6 with words W0..W5 -> writes only at addresses 0..3; err_ovf=1 from the LEN_LO edge; word_cnt ends at 6; done=1.
- Abort and restart: assert rst after 2 data bytes of word 1 -> state IDLE with cpu_rst=1; a new start loads a fresh 1-word image correctly at addr 0. Also assert start during DATA -> ignored.
